// File: rtl/alu_seq_core.sv
// Multi-cycle ALU: registered operands/opcode, start/busy/done handshake,
// single-cycle logic/add/sub, bit-serial shifts and a shift-add multiplier.
module alu_seq_core #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic         load_A,
  input  logic         load_B,
  input  logic         load_Op,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_OR  = 3'd2, OP_AND = 3'd3,
    OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SRA = 3'd6, OP_MUL = 3'd7
  } op_e;

  typedef enum logic {S_IDLE, S_EXEC} state_e;

  state_e         r_state;
  op_e            r_op, r_wop;
  logic [N-1:0]   r_a, r_b, r_wa, r_wb;
  logic [N-1:0]   r_acc;    // shift operand, or high half of the product
  logic [N-1:0]   r_lo;     // multiplier bits, becoming the low half of the product
  logic [CW-1:0]  r_cnt;
  logic           r_carry;
  logic           r_busy, r_done;
  logic [N-1:0]   r_result;
  logic [3:0]     r_flags;

  logic [N:0]     w_sum, w_diff, w_mac;
  logic           w_fin, w_c, w_v, w_carry_nxt;
  logic [N-1:0]   w_res, w_acc_nxt, w_lo_nxt;

  assign w_sum  = {1'b0, r_wa} + {1'b0, r_wb};
  assign w_diff = {1'b0, r_wa} - {1'b0, r_wb};
  assign w_mac  = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_wa} : '0);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_fin       = 1'b0;
    w_res       = r_acc;
    w_c         = 1'b0;
    w_v         = 1'b0;
    w_acc_nxt   = r_acc;
    w_lo_nxt    = r_lo;
    w_carry_nxt = r_carry;
    unique case (r_wop)
      OP_ADD: begin
        w_fin = 1'b1;
        w_res = w_sum[N-1:0];
        w_c   = w_sum[N];
        w_v   = (r_wa[N-1] == r_wb[N-1]) && (w_sum[N-1] != r_wa[N-1]);
      end
      OP_SUB: begin
        w_fin = 1'b1;
        w_res = w_diff[N-1:0];
        w_c   = w_diff[N];
        w_v   = (r_wa[N-1] != r_wb[N-1]) && (w_diff[N-1] != r_wa[N-1]);
      end
      OP_OR:  begin w_fin = 1'b1; w_res = r_wa | r_wb; end
      OP_AND: begin w_fin = 1'b1; w_res = r_wa & r_wb; end
      OP_XOR: begin w_fin = 1'b1; w_res = r_wa ^ r_wb; end
      OP_SHL: begin
        if (r_cnt == '0) begin
          w_fin = 1'b1;
          w_c   = r_carry;
        end else begin
          w_acc_nxt   = {r_acc[N-2:0], 1'b0};
          w_carry_nxt = r_acc[N-1];
        end
      end
      OP_SRA: begin
        if (r_cnt == '0) begin
          w_fin = 1'b1;
          w_c   = r_carry;
        end else begin
          w_acc_nxt   = {r_acc[N-1], r_acc[N-1:1]};
          w_carry_nxt = r_acc[0];
        end
      end
      OP_MUL: begin
        // The final partial product is folded in on the same edge that retires the result.
        w_acc_nxt = w_mac[N:1];
        w_lo_nxt  = {w_mac[0], r_lo[N-1:1]};
        if (r_cnt == '0) begin
          w_fin = 1'b1;
          w_res = w_lo_nxt;
          w_c   = |w_acc_nxt;
        end
      end
      default: w_fin = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= OP_ADD;
      r_wop    <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_wa     <= '0;
      r_wb     <= '0;
      r_acc    <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (load_A)  r_a  <= data_in;
          if (load_B)  r_b  <= data_in;
          if (load_Op) r_op <= op_e'(data_in[2:0]);
          if (start) begin
            // Snapshot uses pre-edge operands even when a load shares this edge.
            r_wa    <= r_a;
            r_wb    <= r_b;
            r_wop   <= r_op;
            r_acc   <= (r_op == OP_MUL) ? '0 : r_a;
            r_lo    <= r_b;
            r_cnt   <= (r_op == OP_MUL) ? CW'(N - 1) : r_b[CW-1:0];
            r_carry <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_fin) begin
            r_result <= w_res;
            r_flags  <= {w_res[N-1], (w_res == '0), w_c, w_v};
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_acc   <= w_acc_nxt;
            r_lo    <= w_lo_nxt;
            r_carry <= w_carry_nxt;
            r_cnt   <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign flags  = r_flags;

endmodule
